bit_modified_carry_look_gate_level: RTL and testbench



---
 rtl/bit_modified_carry_look_gate_level_if.sv | 10 +
 rtl/bit_modified_carry_look_gate_level.sv | 137 +++++++++++++
 tb/tb_bit_modified_carry_look_gate_level.sv | 112 +++++++++++
 3 files changed

// File: rtl/bit_modified_carry_look_gate_level_if.sv
// Operand/result bundle for the registered 32-bit gate-level CLA adder.
interface bit_modified_carry_look_gate_level_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] sum;
   logic        cout;

   modport master (output a, b, input sum, cout);
   modport slave  (input a, b, output sum, cout);
endinterface

// File: rtl/bit_modified_carry_look_gate_level.sv
// 32-bit modified carry-lookahead adder from primitive gates, registered result.
// Optional input register stage under BMCLA_INPUT_REG_EN (latency 2 instead of 1).

// 4-bit group: internal carries plus group propagate/generate.
module bmcla_grp (
   input  wire [3:0] p,
   input  wire [3:0] g,
   input  wire       ci,
   output wire [3:1] c,
   output wire       gp,
   output wire       gg
);
   wire t10, t20, t21, t30, t31, t32, tg0, tg1, tg2;

   and (t10, p[0], ci);
   or  (c[1], g[0], t10);

   and (t20, p[1], g[0]);
   and (t21, p[1], p[0], ci);
   or  (c[2], g[1], t20, t21);

   and (t30, p[2], g[1]);
   and (t31, p[2], p[1], g[0]);
   and (t32, p[2], p[1], p[0], ci);
   or  (c[3], g[2], t30, t31, t32);

   and (tg0, p[3], g[2]);
   and (tg1, p[3], p[2], g[1]);
   and (tg2, p[3], p[2], p[1], g[0]);
   or  (gg, g[3], tg0, tg1, tg2);
   and (gp, p[3], p[2], p[1], p[0]);
endmodule

// Second-level lookahead over four groups: carries into groups 1..3 and out of group 3.
module bmcla_lcu (
   input  wire [3:0] gp,
   input  wire [3:0] gg,
   input  wire       ci,
   output wire [4:1] c
);
   wire t10, t20, t21, t30, t31, t32, t40, t41, t42, t43;

   and (t10, gp[0], ci);
   or  (c[1], gg[0], t10);

   and (t20, gp[1], gg[0]);
   and (t21, gp[1], gp[0], ci);
   or  (c[2], gg[1], t20, t21);

   and (t30, gp[2], gg[1]);
   and (t31, gp[2], gp[1], gg[0]);
   and (t32, gp[2], gp[1], gp[0], ci);
   or  (c[3], gg[2], t30, t31, t32);

   and (t40, gp[3], gg[2]);
   and (t41, gp[3], gp[2], gg[1]);
   and (t42, gp[3], gp[2], gp[1], gg[0]);
   and (t43, gp[3], gp[2], gp[1], gp[0], ci);
   or  (c[4], gg[3], t40, t41, t42, t43);
endmodule

module bit_modified_carry_look_gate_level (
   input logic clk,
   input logic rst_n,
   bit_modified_carry_look_gate_level_if.slave bus
);
   wire [31:0] ca, cb;
   wire [31:0] p, g, c, s;
   wire [7:0]  gp, gg, grp_c;
   wire [4:1]  c_u0, c_u1;
   wire        cin0;

`ifdef BMCLA_INPUT_REG_EN
   logic [31:0] a_q, b_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= bus.a;
         b_q <= bus.b;
      end
   end

   assign ca = a_q;
   assign cb = b_q;
`else
   assign ca = bus.a;
   assign cb = bus.b;
`endif

   assign cin0 = 1'b0;

   genvar i, k;
   generate
      for (i = 0; i < 32; i++) begin : g_bit
         xor (p[i], ca[i], cb[i]);
         and (g[i], ca[i], cb[i]);
         xor (s[i], p[i], c[i]);
      end

      // Group carry-in comes from the second level; the group fills in bits 1..3.
      for (k = 0; k < 8; k++) begin : g_grp
         assign c[4*k] = grp_c[k];
         bmcla_grp u_grp (
            .p  (p[4*k+3:4*k]),
            .g  (g[4*k+3:4*k]),
            .ci (grp_c[k]),
            .c  (c[4*k+3:4*k+1]),
            .gp (gp[k]),
            .gg (gg[k])
         );
      end
   endgenerate

   bmcla_lcu u_lcu0 (.gp(gp[3:0]), .gg(gg[3:0]), .ci(cin0),    .c(c_u0));
   bmcla_lcu u_lcu1 (.gp(gp[7:4]), .gg(gg[7:4]), .ci(c_u0[4]), .c(c_u1));

   assign grp_c = {c_u1[3:1], c_u0[4:1], cin0};

   logic [31:0] sum_q;
   logic        cout_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= s;
         cout_q <= c_u1[4];
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_modified_carry_look_gate_level.sv
// Directed + random checks of the registered gate-level CLA adder (either latency build).
module tb_bit_modified_carry_look_gate_level;
`ifdef BMCLA_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   bit_modified_carry_look_gate_level_if bus ();

   bit_modified_carry_look_gate_level dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got cout/sum=%h, expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp);
      bus.a = a;
      bus.b = b;
      repeat (LAT) step();
      chk(tag, {bus.cout, bus.sum}, exp);
   endtask

   logic [31:0] sa [2];
   logic [31:0] sb [2];
   logic [32:0] se [2];
   logic [32:0] q [$];
   logic [31:0] ra, rb;
   logic [32:0] ref_sum;

   initial begin
      bus.a = 32'hFFFFFFFF;
      bus.b = 32'hFFFFFFFF;
      rst_n = 1'b0;
      repeat (2) step();
      chk("reset", {bus.cout, bus.sum}, 33'h0);
      rst_n = 1'b1;

      apply("small1",   32'h00000001, 32'h00000001, 33'h0_00000002);
      apply("small2",   32'h11110002, 32'h11110002, 33'h0_22220004);
      apply("topcarry", 32'hFFFF0006, 32'h12560006, 33'h1_1255000C);
      apply("chain1",   32'hDEDCFFFF, 32'hFEDCFFFF, 33'h1_DDB9FFFE);
      apply("chain2",   32'hFFFFFFFF, 32'h00000001, 33'h1_00000000);
      apply("zero",     32'h00000000, 32'h00000000, 33'h0_00000000);
      apply("alt",      32'hAAAAAAAA, 32'h55555555, 33'h0_FFFFFFFF);

      // Back-to-back stream: one result per cycle after the pipeline fills.
      sa[0] = 32'hFEFEF1EF; sb[0] = 32'hFEFEF1EF; se[0] = 33'h1_FDFDE3DE;
      sa[1] = 32'h00110110; sb[1] = 32'h11000110; se[1] = 33'h0_11110220;
      for (int i = 0; i < 2 + LAT - 1; i++) begin
         if (i < 2) begin
            bus.a = sa[i];
            bus.b = sb[i];
         end
         step();
         if (i - LAT + 1 >= 0)
            chk($sformatf("stream%0d", i - LAT + 1), {bus.cout, bus.sum}, se[i - LAT + 1]);
      end

      // Reset asserted between edges must not disturb the registered output.
      apply("pre_rst", 32'h00000005, 32'h00000003, 33'h0_00000008);
      #2;
      rst_n = 1'b0;
      bus.a = 32'h12345678;
      bus.b = 32'h11111111;
      #1;
      chk("rst_sync_hold", {bus.cout, bus.sum}, 33'h0_00000008);
      step();
      chk("rst_mid", {bus.cout, bus.sum}, 33'h0);
      rst_n = 1'b1;
      bus.a = 32'h80000000;
      bus.b = 32'h80000000;
      step();
      chk("resume1", {bus.cout, bus.sum}, (LAT == 1) ? 33'h1_00000000 : 33'h0);
      if (LAT == 2) begin
         step();
         chk("resume2", {bus.cout, bus.sum}, 33'h1_00000000);
      end

      // Random stream against a 33-bit reference sum.
      for (int i = 0; i < 10000 + LAT - 1; i++) begin
         if (i < 10000) begin
            ra = $urandom;
            rb = $urandom;
            bus.a = ra;
            bus.b = rb;
            ref_sum = {1'b0, ra} + {1'b0, rb};
            q.push_back(ref_sum);
         end
         step();
         if (i >= LAT - 1) chk("random", {bus.cout, bus.sum}, q.pop_front());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
